// File: rtl/chimp_pkg.sv
// Shared types and defaults for the chimp-test round sequencer.
package chimp_pkg;

   localparam int W           = 5;
   localparam int START_NUMS  = 4;
   localparam int MAX_NUMS    = 31;
   localparam int MAX_STRIKES = 3;

   typedef enum logic [3:0] {
      S_IDLE,
      S_IDLE_WAIT,
      S_CLEAR,
      S_LOAD,
      S_SHOW,
      S_CHOOSE,
      S_ROUND_WIN,
      S_ROUND_FAIL,
      S_GAME_OVER
   } state_t;

   // Numbers on the board for a given level: start + level - 1, capped at max.
   // The sum is formed one bit wider than a level so the cap test cannot wrap.
   function automatic logic [W-1:0] round_size(
      input logic [W-1:0] level,
      input int unsigned  start_nums = START_NUMS,
      input int unsigned  max_nums   = MAX_NUMS
   );
      logic [W:0] sum;
      sum = (W+1)'(start_nums) + {1'b0, level} - (W+1)'(1);
      if (sum > (W+1)'(max_nums)) begin
         return W'(max_nums);
      end
      return sum[W-1:0];
   endfunction

endpackage

// File: rtl/chimp_round_sequencer_space_edge_detect.sv
// Space-key press-then-release detector. While enabled it arms on a press
// and emits a one-cycle released pulse when the key goes back up. Disabling
// it drops any half-seen press so keys hit during play are never carried over.
module space_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic space,
   output logic released
);

   logic armed_d;
   logic armed_q;

   // Next arm state: set on press, cleared on release or when not listening.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      armed_d = armed_q;
      if (!enable) begin
         armed_d = 1'b0;
      end else if (space) begin
         armed_d = 1'b1;
      end else if (armed_q) begin
         armed_d = 1'b0;
      end
   end

   // Arm flop; the pulse lasts one cycle because the flop clears on release.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         armed_q <= 1'b0;
      end else begin
         armed_q <= armed_d;
      end
   end

   assign released = enable && armed_q && !space;

endmodule

// File: rtl/chimp_round_sequencer.sv
// Round sequencer for the chimp-test game: clears the board, loads 1..N
// through a handshake, shows then hides the numbers, checks clicks in order
// and keeps level, strikes and game-over. All outputs are registered.
module chimp_round_sequencer
   import chimp_pkg::*;
#(
   parameter int START_NUMS_P  = chimp_pkg::START_NUMS,
   parameter int MAX_NUMS_P    = chimp_pkg::MAX_NUMS,
   parameter int MAX_STRIKES_P = chimp_pkg::MAX_STRIKES
) (
   input  logic         iClock,
   input  logic         iReset,
   input  logic         iSpace,
   input  logic         iDoneLoad,
   input  logic         iClickValid,
   input  logic [W-1:0] iClickNum,
   output logic [W-1:0] oLevel,
   output logic [W-1:0] oNumToLoad,
   output logic [W-1:0] oNumToChoose,
   output logic         oLoadEnable,
   output logic         oShowEnable,
   output logic         oResetBoard,
   output logic [1:0]   oStrikes,
   output logic         oRoundPass,
   output logic         oGameOver
);

   localparam logic [W-1:0] ONE        = W'(1);
   localparam logic [W-1:0] N_CAP      = W'(MAX_NUMS_P);
   localparam logic [1:0]   STRIKE_CAP = 2'(MAX_STRIKES_P);

   state_t       state_d, state_q;
   logic [W-1:0] level_d, level_q;
   logic [1:0]   strikes_d, strikes_q;
   logic [W-1:0] k_d, k_q;
   logic [W-1:0] e_d, e_q;

   logic [W-1:0] num_to_load_d, num_to_load_q;
   logic [W-1:0] num_to_choose_d, num_to_choose_q;
   logic         load_enable_d, load_enable_q;
   logic         show_enable_d, show_enable_q;
   logic         reset_board_d, reset_board_q;
   logic         round_pass_d, round_pass_q;
   logic         game_over_d, game_over_q;

   logic [W-1:0] n_round;
   logic         click_hit;
   logic [1:0]   strikes_inc;
   logic         space_wait;
   logic         released;

   assign n_round   = round_size(level_q, START_NUMS_P, MAX_NUMS_P);
   assign click_hit = iClickValid && (iClickNum != '0);

   // The detector only listens in states that wait for a space press.
   assign space_wait = (state_q == S_IDLE)       || (state_q == S_IDLE_WAIT) ||
                       (state_q == S_ROUND_WIN)  || (state_q == S_ROUND_FAIL) ||
                       (state_q == S_GAME_OVER);

   space_edge_detect u_space (
      .clk      (iClock),
      .rst      (iReset),
      .enable   (space_wait),
      .space    (iSpace),
      .released (released)
   );

   // Next state, counters and the registered output values they imply.
   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      strikes_d   = strikes_q;
      k_d         = k_q;
      e_d         = e_q;
      strikes_inc = strikes_q + 2'd1;

      case (state_q)
         S_IDLE: begin
            if (iSpace) begin
               state_d = S_IDLE_WAIT;
            end
         end

         S_IDLE_WAIT: begin
            if (released) begin
               state_d = S_CLEAR;
            end
         end

         S_CLEAR: begin
            k_d     = ONE;
            e_d     = '0;
            state_d = S_LOAD;
         end

         S_LOAD: begin
            if (iDoneLoad) begin
               if (k_q < n_round) begin
                  k_d = k_q + ONE;
               end else begin
                  e_d     = ONE;
                  state_d = S_SHOW;
               end
            end
         end

         // SHOW and CHOOSE differ only in tile visibility; a correct first
         // click in SHOW hides the tiles by moving to CHOOSE.
         S_SHOW, S_CHOOSE: begin
            if (click_hit) begin
               if (iClickNum == e_q) begin
                  if (e_q >= n_round) begin
                     state_d = S_ROUND_WIN;
                     if (n_round != N_CAP) begin
                        level_d = level_q + ONE;
                     end
                  end else begin
                     e_d     = e_q + ONE;
                     state_d = S_CHOOSE;
                  end
               end else begin
                  strikes_d = strikes_inc;
                  state_d   = (strikes_inc == STRIKE_CAP) ? S_GAME_OVER : S_ROUND_FAIL;
               end
            end
         end

         S_ROUND_WIN, S_ROUND_FAIL: begin
            if (released) begin
               state_d = S_CLEAR;
            end
         end

         S_GAME_OVER: begin
            if (released) begin
               level_d   = ONE;
               strikes_d = '0;
               state_d   = S_CLEAR;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      load_enable_d   = (state_d == S_LOAD);
      num_to_load_d   = (state_d == S_LOAD) ? k_d : '0;
      show_enable_d   = (state_d == S_SHOW);
      num_to_choose_d = ((state_d == S_SHOW) || (state_d == S_CHOOSE)) ? e_d : '0;
      reset_board_d   = (state_d == S_CLEAR);
      round_pass_d    = (state_d == S_ROUND_WIN) && (state_q != S_ROUND_WIN);
      game_over_d     = (state_d == S_GAME_OVER);
   end

   // FSM, counters and output registers.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         state_q         <= S_IDLE;
         level_q         <= ONE;
         strikes_q       <= '0;
         k_q             <= '0;
         e_q             <= '0;
         num_to_load_q   <= '0;
         num_to_choose_q <= '0;
         load_enable_q   <= 1'b0;
         show_enable_q   <= 1'b0;
         reset_board_q   <= 1'b0;
         round_pass_q    <= 1'b0;
         game_over_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         level_q         <= level_d;
         strikes_q       <= strikes_d;
         k_q             <= k_d;
         e_q             <= e_d;
         num_to_load_q   <= num_to_load_d;
         num_to_choose_q <= num_to_choose_d;
         load_enable_q   <= load_enable_d;
         show_enable_q   <= show_enable_d;
         reset_board_q   <= reset_board_d;
         round_pass_q    <= round_pass_d;
         game_over_q     <= game_over_d;
      end
   end

   assign oLevel       = level_q;
   assign oStrikes     = strikes_q;
   assign oNumToLoad   = num_to_load_q;
   assign oNumToChoose = num_to_choose_q;
   assign oLoadEnable  = load_enable_q;
   assign oShowEnable  = show_enable_q;
   assign oResetBoard  = reset_board_q;
   assign oRoundPass   = round_pass_q;
   assign oGameOver    = game_over_q;

endmodule

// File: tb/tb_chimp_round_sequencer.sv
// Directed bench for chimp_round_sequencer with hand-computed expectations.
module tb_chimp_round_sequencer;

   localparam int W = 5;

   logic         iClock = 1'b0;
   logic         iReset;
   logic         iSpace;
   logic         iDoneLoad;
   logic         iClickValid;
   logic [W-1:0] iClickNum;
   logic [W-1:0] oLevel;
   logic [W-1:0] oNumToLoad;
   logic [W-1:0] oNumToChoose;
   logic         oLoadEnable;
   logic         oShowEnable;
   logic         oResetBoard;
   logic [1:0]   oStrikes;
   logic         oRoundPass;
   logic         oGameOver;

   int errors = 0;
   int checks = 0;

   chimp_round_sequencer dut (
      .iClock       (iClock),
      .iReset       (iReset),
      .iSpace       (iSpace),
      .iDoneLoad    (iDoneLoad),
      .iClickValid  (iClickValid),
      .iClickNum    (iClickNum),
      .oLevel       (oLevel),
      .oNumToLoad   (oNumToLoad),
      .oNumToChoose (oNumToChoose),
      .oLoadEnable  (oLoadEnable),
      .oShowEnable  (oShowEnable),
      .oResetBoard  (oResetBoard),
      .oStrikes     (oStrikes),
      .oRoundPass   (oRoundPass),
      .oGameOver    (oGameOver)
   );

   always #5 iClock = ~iClock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock and sample 1 ns after the edge.
   task automatic tick();
      @(posedge iClock);
      #1;
   endtask

   task automatic done_pulse();
      iDoneLoad = 1'b1;
      tick();
      iDoneLoad = 1'b0;
   endtask

   task automatic click(input int num);
      iClickValid = 1'b1;
      iClickNum   = W'(num);
      tick();
      iClickValid = 1'b0;
      iClickNum   = '0;
   endtask

   // Full press-release; the board clear strobe must follow the release edge.
   task automatic space_to_clear();
      iSpace = 1'b1;
      tick();
      iSpace = 1'b0;
      tick();
      check("clear_pulse", oResetBoard, 1);
      tick();
      check("clear_one_cycle", oResetBoard, 0);
   endtask

   // Ack n loads, checking the presented number each time, then expect SHOW.
   task automatic load_all(input int n);
      for (int i = 1; i <= n; i++) begin
         check("load_en", oLoadEnable, 1);
         check("load_num", oNumToLoad, i);
         done_pulse();
      end
      check("show_after_load", oShowEnable, 1);
      check("first_choose", oNumToChoose, 1);
      check("load_done", oLoadEnable, 0);
      check("load_num_zero", oNumToLoad, 0);
   endtask

   task automatic click_all(input int n);
      for (int i = 1; i <= n; i++) begin
         click(i);
      end
      check("round_pass", oRoundPass, 1);
   endtask

   initial begin
      iReset      = 1'b1;
      iSpace      = 1'b0;
      iDoneLoad   = 1'b0;
      iClickValid = 1'b0;
      iClickNum   = '0;
      repeat (3) tick();
      check("rst_level", oLevel, 1);
      check("rst_strikes", oStrikes, 0);
      check("rst_load_en", oLoadEnable, 0);
      check("rst_num_load", oNumToLoad, 0);
      check("rst_num_choose", oNumToChoose, 0);
      check("rst_show", oShowEnable, 0);
      check("rst_clear", oResetBoard, 0);
      check("rst_pass", oRoundPass, 0);
      check("rst_gameover", oGameOver, 0);
      iReset = 1'b0;
      tick();

      // Stray inputs in IDLE do nothing.
      click(1);
      done_pulse();
      check("idle_ignore_load", oLoadEnable, 0);
      check("idle_ignore_strikes", oStrikes, 0);

      // Press alone must not clear; the release does.
      iSpace = 1'b1;
      tick();
      check("press_no_clear", oResetBoard, 0);
      tick();
      check("held_no_clear", oResetBoard, 0);
      iSpace = 1'b0;
      tick();
      check("release_clear", oResetBoard, 1);
      check("clear_no_load", oLoadEnable, 0);
      tick();
      check("clear_one_cycle", oResetBoard, 0);

      // Datapath slow to ack: request stays stable; clicks during LOAD ignored.
      repeat (10) tick();
      check("holdoff_num", oNumToLoad, 1);
      check("holdoff_en", oLoadEnable, 1);
      click(1);
      check("load_click_num", oNumToLoad, 1);
      check("load_click_show", oShowEnable, 0);
      check("load_click_strikes", oStrikes, 0);
      load_all(4);

      // SHOW: stray done and empty-tile clicks are ignored.
      done_pulse();
      check("show_ignore_done", oShowEnable, 1);
      check("show_ignore_done_e", oNumToChoose, 1);
      click(0);
      check("empty_click_show", oShowEnable, 1);
      check("empty_click_e", oNumToChoose, 1);
      check("empty_click_strikes", oStrikes, 0);

      click(1);
      check("choose_hidden", oShowEnable, 0);
      check("choose_e2", oNumToChoose, 2);
      click(0);
      check("choose_empty_e", oNumToChoose, 2);
      click(2);
      click(3);
      check("choose_e4", oNumToChoose, 4);
      click(4);
      check("win_pass", oRoundPass, 1);
      check("win_level", oLevel, 2);
      check("win_choose_zero", oNumToChoose, 0);
      tick();
      check("win_pass_once", oRoundPass, 0);
      click(1);
      check("win_ignore_click", oStrikes, 0);
      check("win_ignore_level", oLevel, 2);

      // Level 2: N = 5. Wrong second click -> strike.
      space_to_clear();
      load_all(5);
      click(1);
      click(3);
      check("fail1_strikes", oStrikes, 1);
      check("fail1_level", oLevel, 2);
      check("fail1_choose", oNumToChoose, 0);
      check("fail1_pass", oRoundPass, 0);
      check("fail1_gameover", oGameOver, 0);

      // Replay keeps N = 5; wrong first click in SHOW.
      space_to_clear();
      load_all(5);
      click(2);
      check("fail2_strikes", oStrikes, 2);
      check("fail2_show", oShowEnable, 0);

      // Third failure with an out-of-range tile number ends the game.
      space_to_clear();
      load_all(5);
      click(1);
      click(2);
      click(3);
      click(4);
      click(31);
      check("fail3_strikes", oStrikes, 3);
      check("gameover", oGameOver, 1);
      click(5);
      done_pulse();
      check("go_ignore_strikes", oStrikes, 3);
      check("go_ignore_load", oLoadEnable, 0);
      check("go_hold", oGameOver, 1);

      space_to_clear();
      check("restart_level", oLevel, 1);
      check("restart_strikes", oStrikes, 0);
      check("restart_gameover", oGameOver, 0);
      load_all(4);
      click_all(4);
      check("restart_win_level", oLevel, 2);

      // Climb to level 28, where N reaches 31.
      for (int lvl = 2; lvl <= 27; lvl++) begin
         space_to_clear();
         load_all(lvl + 3);
         click_all(lvl + 3);
         check("climb_level", oLevel, lvl + 1);
      end
      space_to_clear();
      load_all(31);
      click_all(31);
      check("sat_level", oLevel, 28);

      // Asynchronous reset in the middle of LOAD.
      space_to_clear();
      done_pulse();
      done_pulse();
      done_pulse();
      check("mid_load_num", oNumToLoad, 4);
      #2;
      iReset = 1'b1;
      #1;
      check("async_load_en", oLoadEnable, 0);
      check("async_num_load", oNumToLoad, 0);
      check("async_level", oLevel, 1);
      check("async_strikes", oStrikes, 0);
      check("async_show", oShowEnable, 0);
      check("async_gameover", oGameOver, 0);
      tick();
      iReset = 1'b0;
      tick();
      check("post_rst_idle", oLoadEnable, 0);
      check("post_rst_clear", oResetBoard, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
